pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Parametrised program-counter and run-control unit for the 32-bit MIPS single-cycle core. It replaces the fixed PC register and computes the next PC (sequential, BEQ, J). It adds a programmable wrap limit and a synchronised run/halt/single-step controller driven by board switch and button. Its `commit` output lets the datapath gate register-file and data-memory writes, so nothing is written while the core is halted.

## Interface
Parameters:
- `PC_W`, 32: PC width; legal range 28..32.
- `RESET_PC`, 0: PC value after reset and after a wrap.
- `LIMIT_DEFAULT`, 12: wrap limit after reset.
- `CNT_W`, 16: retire counter width.

Ports:
- `clock`  in  1  system clock; only clock in the block.
- `reset`  in  1  synchronous, active-high; highest priority.
- `hold_in`  in  1  raw switch level (asynchronous); 1 requests halt.
- `step_in`  in  1  raw button (asynchronous); rising edge requests one step while halted.
- `branch_en`  in  1  control-unit branch signal.
- `zero_flag`  in  1  ALU zero flag.
- `imm16`  in  16  instruction[15:0].
- `jump_en`  in  1  J-type decode.
- `jump_idx`  in  26  instruction[25:0].
- `limit_we`  in  1  load wrap limit.
- `limit_data`  in  PC_W  new limit; bits [1:0] forced to 0 on load.
- `pc_out`  out  PC_W  current PC (registered).
- `pc_plus4`  out  PC_W  `pc_out + 4` (combinational).
- `commit`  out  1  instruction at `pc_out` retires this cycle (combinational from state).
- `wrap_pulse`  out  1  registered; high one cycle after a wrap.
- `retire_count`  out  CNT_W  retired instructions, modulo 2^CNT_W.
- `mode`  out  2  FSM state: 00 RUN, 01 HALT, 10 STEP.

## Operation
- Synchronisers: `hold_in` passes through 2 flops to give `hold_s`. `step_in` passes through 2 flops plus a delay flop; `step_pulse = s2 & ~s3`. All synchroniser flops reset to 0.
- FSM:
  - RUN → HALT when `hold_s` = 1.
  - HALT → STEP on `step_pulse`.
  - HALT → RUN when `hold_s` = 0; `step_pulse` wins if both occur.
  - STEP → HALT if `hold_s` = 1, else → RUN.
  - `step_pulse` is ignored in RUN and STEP.
- `commit` = (mode == RUN) | (mode == STEP). The PC, `retire_count` and `wrap_pulse` update only when `commit` = 1.
- Next-PC priority, all arithmetic modulo 2^PC_W:
  - Wrap: if `pc_out == limit`, next = `RESET_PC` and `wrap_pulse` is set next cycle.
  - Jump: `jump_en` gives `{pc_plus4[PC_W-1:28], jump_idx, 2'b00}`.
  - Branch: `branch_en & zero_flag` gives `pc_plus4 + (sign_ext(imm16) << 2)`. Negative offsets are two's-complement adds.
  - Otherwise: `pc_plus4`.
- Wrap is equality only. A jump or branch that skips past `limit` does not wrap.
- `limit_we` loads the limit at the clock edge. The wrap compare in that same cycle uses the old limit.
- `retire_count` increments on every commit, wraps to 0 on overflow, and counts wrap cycles too.

## Timing
- Reset (synchronous): `pc_out` = RESET_PC, `mode` = RUN, limit = LIMIT_DEFAULT, `retire_count` = 0, `wrap_pulse` = 0, synchronisers cleared. `commit` = 1 in the first cycle after reset. Reset overrides `limit_we`, jumps and steps; asserting it mid-step aborts the step.
- `hold_in` rising before edge k: `pc_out` still updates at edges k, k+1 and k+2 (mode = HALT after k+2). It is frozen from edge k+3.
- `hold_in` falling before edge k: mode = RUN after k+2, and advancing resumes at edge k+3.
- `step_in` rising before edge k while HALT: mode = STEP after k+2, exactly one PC update at k+3, then mode returns to HALT. A held button gives one step only; a new step needs a new rising edge.
- While mode = HALT: `commit` = 0, and `pc_out`, `retire_count` and `wrap_pulse` are stable.
- Next-PC latency is 0 (combinational); PC update latency is 1 edge.

## Test plan
- Reset, then run: `pc_out` steps 0, 4, 8, 12, 0. `wrap_pulse` is high exactly in the cycle after the 12→0 update. `retire_count` = 5 after 5 commits.
- Raise `limit_we` with `limit_data` = 0x1B. The limit loads as 0x18 and the PC wraps after 0x18. Hold `limit_we` in the cycle where `pc_out` = 12: that cycle still wraps to 0 (old limit).
- Branch at `pc_out` = 8 with `imm16` = 0xFFFE and `zero_flag` = 1: next PC = 4. With `zero_flag` = 0: next PC = 12. `jump_en` with `jump_idx` = 0x000001 at the same time: next PC = 4 (jump wins).
- Raise `hold_in` before edge k: 3 further PC updates, then frozen for 50 cycles with `commit` = 0. Pulse `step_in` for 5 cycles: exactly one update at edge +3. Lower `hold_in`: PC runs again.
- Assert `reset` for one cycle in mode STEP while `pc_out` = 8: next cycle `pc_out` = 0, `mode` = RUN, `retire_count` = 0, `wrap_pulse` = 0.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program counter and run/halt/single-step control for the single-cycle MIPS core.
// Latency: next PC is combinational from the current state; pc_out updates one edge later.
// Halt: commit drops to 0 and PC, retire count and wrap pulse hold until the next step or run.
module pc_sequencer #(
  parameter int              PC_W          = 32,
  parameter logic [PC_W-1:0] RESET_PC      = '0,
  parameter logic [PC_W-1:0] LIMIT_DEFAULT = PC_W'(12),
  parameter int              CNT_W         = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              hold_in,
  input  logic              step_in,
  input  logic              branch_en,
  input  logic              zero_flag,
  input  logic [15:0]       imm16,
  input  logic              jump_en,
  input  logic [25:0]       jump_idx,
  input  logic              limit_we,
  input  logic [PC_W-1:0]   limit_data,
  output logic [PC_W-1:0]   pc_out,
  output logic [PC_W-1:0]   pc_plus4,
  output logic              commit,
  output logic              wrap_pulse,
  output logic [CNT_W-1:0]  retire_count,
  output logic [1:0]        mode
);

  typedef enum logic [1:0] {
    MODE_RUN  = 2'b00,
    MODE_HALT = 2'b01,
    MODE_STEP = 2'b10
  } mode_e;

  // Word alignment mask for the wrap limit, and the mask that keeps the
  // PC region bits above the 28-bit jump field.
  localparam logic [PC_W-1:0] ALIGN_MASK = {{(PC_W-2){1'b1}}, 2'b00};
  localparam logic [PC_W-1:0] LOW_MASK   = PC_W'(28'hFFF_FFFF);

  mode_e             state;
  mode_e             state_nxt;
  logic              hold_s1;
  logic              hold_s;
  logic              step_s1;
  logic              step_s2;
  logic              step_s3;
  logic              step_pulse;
  logic [PC_W-1:0]   limit;
  logic [PC_W-1:0]   pc_next;
  logic [PC_W-1:0]   br_offset;
  logic [PC_W-1:0]   jump_target;
  logic              is_wrap;

  // Two-flop synchronisers for the switch and button, plus an edge-detect flop on the button
  always_ff @(posedge clock) begin
    if (reset) begin
      hold_s1 <= 1'b0;
      hold_s  <= 1'b0;
      step_s1 <= 1'b0;
      step_s2 <= 1'b0;
      step_s3 <= 1'b0;
    end else begin
      hold_s1 <= hold_in;
      hold_s  <= hold_s1;
      step_s1 <= step_in;
      step_s2 <= step_s1;
      step_s3 <= step_s2;
    end
  end

  // A held button yields a single one-cycle pulse
  assign step_pulse = step_s2 & ~step_s3;

  // Run-control state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= MODE_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Run-control next state; a step request beats a simultaneous release of hold
  always_comb begin
    state_nxt = state;
    case (state)
      MODE_RUN:  if (hold_s) state_nxt = MODE_HALT;
      MODE_HALT: begin
        if (step_pulse)   state_nxt = MODE_STEP;
        else if (!hold_s) state_nxt = MODE_RUN;
      end
      MODE_STEP: state_nxt = hold_s ? MODE_HALT : MODE_RUN;
      default:   state_nxt = MODE_RUN;
    endcase
  end

  assign mode     = state;
  assign commit   = (state == MODE_RUN) || (state == MODE_STEP);
  assign pc_plus4 = pc_out + PC_W'(4);

  assign br_offset   = {{(PC_W-18){imm16[15]}}, imm16, 2'b00};
  assign jump_target = (pc_plus4 & ~LOW_MASK) | PC_W'({jump_idx, 2'b00});
  assign is_wrap     = (pc_out == limit);

  // Next-PC select: wrap beats jump beats taken branch beats sequential
  always_comb begin
    pc_next = pc_plus4;
    if (is_wrap) begin
      pc_next = RESET_PC;
    end else if (jump_en) begin
      pc_next = jump_target;
    end else if (branch_en && zero_flag) begin
      pc_next = pc_plus4 + br_offset;
    end
  end

  // PC, limit, wrap flag and retire counter; only committed cycles advance the PC side
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_out       <= RESET_PC;
      limit        <= LIMIT_DEFAULT;
      wrap_pulse   <= 1'b0;
      retire_count <= '0;
    end else begin
      // The compare above still sees the old limit during the load cycle
      if (limit_we) begin
        limit <= limit_data & ALIGN_MASK;
      end
      if (commit) begin
        pc_out       <= pc_next;
        wrap_pulse   <= is_wrap;
        retire_count <= retire_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: run, wrap, limit load, branch/jump, hold/step and reset.
// Inputs are driven and outputs sampled 1 ns after each rising edge.
// Every comparison goes through check_val.
module tb_pc_sequencer;

  logic        clock;
  logic        reset;
  logic        hold_in;
  logic        step_in;
  logic        branch_en;
  logic        zero_flag;
  logic [15:0] imm16;
  logic        jump_en;
  logic [25:0] jump_idx;
  logic        limit_we;
  logic [31:0] limit_data;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        commit;
  logic        wrap_pulse;
  logic [15:0] retire_count;
  logic [1:0]  mode;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] M_RUN  = 2'b00;
  localparam logic [1:0] M_HALT = 2'b01;
  localparam logic [1:0] M_STEP = 2'b10;

  pc_sequencer dut (
    .clock        (clock),
    .reset        (reset),
    .hold_in      (hold_in),
    .step_in      (step_in),
    .branch_en    (branch_en),
    .zero_flag    (zero_flag),
    .imm16        (imm16),
    .jump_en      (jump_en),
    .jump_idx     (jump_idx),
    .limit_we     (limit_we),
    .limit_data   (limit_data),
    .pc_out       (pc_out),
    .pc_plus4     (pc_plus4),
    .commit       (commit),
    .wrap_pulse   (wrap_pulse),
    .retire_count (retire_count),
    .mode         (mode)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset      = 1'b1;
    hold_in    = 1'b0;
    step_in    = 1'b0;
    branch_en  = 1'b0;
    zero_flag  = 1'b0;
    imm16      = 16'h0000;
    jump_en    = 1'b0;
    jump_idx   = 26'h0;
    limit_we   = 1'b0;
    limit_data = 32'h0;

    // Reset state
    tick();
    tick();
    check_val("rst_pc", pc_out, 32'h0);
    check_val("rst_mode", mode, M_RUN);
    check_val("rst_retire", retire_count, 16'd0);
    check_val("rst_wrap", wrap_pulse, 1'b0);
    check_val("rst_commit", commit, 1'b1);
    check_val("rst_plus4", pc_plus4, 32'h4);
    reset = 1'b0;

    // Free run 0,4,8,12,0 with the default limit of 12
    tick(); check_val("run_pc4", pc_out, 32'h4);
    tick(); check_val("run_pc8", pc_out, 32'h8);
    tick(); check_val("run_pc12", pc_out, 32'hC);
    check_val("run_wrap_lo", wrap_pulse, 1'b0);
    tick(); check_val("run_pc0", pc_out, 32'h0);
    check_val("run_wrap_hi", wrap_pulse, 1'b1);
    check_val("run_retire4", retire_count, 16'd4);
    tick(); check_val("run_pc4b", pc_out, 32'h4);
    check_val("run_wrap_clr", wrap_pulse, 1'b0);
    check_val("run_retire5", retire_count, 16'd5);

    // Limit load during the cycle at pc=12: old limit still wraps, new limit is 0x18
    tick(); check_val("lim_pc8", pc_out, 32'h8);
    tick(); check_val("lim_pc12", pc_out, 32'hC);
    limit_we   = 1'b1;
    limit_data = 32'h1B;
    tick(); check_val("lim_oldwrap_pc", pc_out, 32'h0);
    check_val("lim_oldwrap_pulse", wrap_pulse, 1'b1);
    limit_we = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check_val("lim_seq_pc", pc_out, 32'(i * 4));
      check_val("lim_seq_wrap", wrap_pulse, 1'b0);
    end
    tick(); check_val("lim_newwrap_pc", pc_out, 32'h0);
    check_val("lim_newwrap_pulse", wrap_pulse, 1'b1);
    check_val("lim_retire", retire_count, 16'd15);

    // Branch and jump at pc=8
    tick(); check_val("br_pc4", pc_out, 32'h4);
    tick(); check_val("br_pc8", pc_out, 32'h8);
    branch_en = 1'b1; zero_flag = 1'b1; imm16 = 16'hFFFE;
    check_val("br_plus4", pc_plus4, 32'hC);
    tick(); check_val("br_taken_back", pc_out, 32'h4);
    branch_en = 1'b0;
    tick(); check_val("br_pc8b", pc_out, 32'h8);
    branch_en = 1'b1; zero_flag = 1'b0;
    tick(); check_val("br_not_taken", pc_out, 32'hC);
    branch_en = 1'b0; jump_en = 1'b1; jump_idx = 26'h2;
    tick(); check_val("jmp_to8", pc_out, 32'h8);
    branch_en = 1'b1; zero_flag = 1'b1; imm16 = 16'hFFFE; jump_idx = 26'h1;
    tick(); check_val("jmp_beats_br", pc_out, 32'h4);
    branch_en = 1'b0; zero_flag = 1'b0; imm16 = 16'h0; jump_en = 1'b0; jump_idx = 26'h0;
    check_val("br_retire", retire_count, 16'd22);

    // Hold: three more updates, then frozen
    hold_in = 1'b1;
    tick(); check_val("hold_k_pc", pc_out, 32'h8);
    check_val("hold_k_mode", mode, M_RUN);
    tick(); check_val("hold_k1_pc", pc_out, 32'hC);
    check_val("hold_k1_mode", mode, M_RUN);
    tick(); check_val("hold_k2_pc", pc_out, 32'h10);
    check_val("hold_k2_mode", mode, M_HALT);
    check_val("hold_k2_commit", commit, 1'b0);
    for (int i = 0; i < 50; i++) begin
      tick();
      check_val("halt_pc", pc_out, 32'h10);
      check_val("halt_commit", commit, 1'b0);
    end
    check_val("halt_retire", retire_count, 16'd25);
    check_val("halt_wrap", wrap_pulse, 1'b0);

    // Step button held for 5 cycles: exactly one update
    step_in = 1'b1;
    tick(); check_val("step_k_mode", mode, M_HALT);
    check_val("step_k_pc", pc_out, 32'h10);
    tick(); check_val("step_k1_mode", mode, M_HALT);
    tick(); check_val("step_k2_mode", mode, M_STEP);
    check_val("step_k2_commit", commit, 1'b1);
    check_val("step_k2_pc", pc_out, 32'h10);
    tick(); check_val("step_k3_pc", pc_out, 32'h14);
    check_val("step_k3_mode", mode, M_HALT);
    check_val("step_k3_commit", commit, 1'b0);
    tick(); check_val("step_k4_pc", pc_out, 32'h14);
    step_in = 1'b0;
    repeat (5) tick();
    check_val("step_after_pc", pc_out, 32'h14);
    check_val("step_after_mode", mode, M_HALT);
    check_val("step_retire", retire_count, 16'd26);

    // Release hold: run resumes at edge k+3
    hold_in = 1'b0;
    tick(); check_val("rel_k_mode", mode, M_HALT);
    tick(); check_val("rel_k1_pc", pc_out, 32'h14);
    tick(); check_val("rel_k2_mode", mode, M_RUN);
    check_val("rel_k2_pc", pc_out, 32'h14);
    tick(); check_val("rel_k3_pc", pc_out, 32'h18);

    // Halt again so that pc=8 when mode reaches HALT
    hold_in = 1'b1;
    tick(); check_val("rel_wrap_pc", pc_out, 32'h0);
    check_val("rel_wrap_pulse", wrap_pulse, 1'b1);
    tick(); check_val("h2_pc4", pc_out, 32'h4);
    tick(); check_val("h2_pc8", pc_out, 32'h8);
    check_val("h2_mode", mode, M_HALT);
    check_val("h2_retire", retire_count, 16'd30);

    // Reset while in STEP at pc=8
    step_in = 1'b1;
    tick(); tick();
    tick(); check_val("rs_step_mode", mode, M_STEP);
    check_val("rs_step_pc", pc_out, 32'h8);
    reset = 1'b1; step_in = 1'b0; hold_in = 1'b0;
    tick();
    check_val("rs_pc", pc_out, 32'h0);
    check_val("rs_mode", mode, M_RUN);
    check_val("rs_retire", retire_count, 16'd0);
    check_val("rs_wrap", wrap_pulse, 1'b0);
    check_val("rs_commit", commit, 1'b1);
    reset = 1'b0;

    // Limit returns to the default of 12 after reset
    tick(); check_val("rs_run_pc4", pc_out, 32'h4);
    tick(); check_val("rs_run_pc8", pc_out, 32'h8);
    tick(); check_val("rs_run_pc12", pc_out, 32'hC);
    tick(); check_val("rs_run_wrap_pc", pc_out, 32'h0);
    check_val("rs_run_wrap_pulse", wrap_pulse, 1'b1);
    check_val("rs_run_retire", retire_count, 16'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
